fp_wb_scheduler: RTL and testbench

Arbitration controller for the shared FP writeback port.
- Collects completed results from three producers: LOAD (data-memory FLW return), MOV (move block) and CVT (conversion/normalization unit).
- Buffers one result per producer and grants one result per cycle.
- Drives registered writeback select, data, destination and enables into the writeback stage and the FP/INT register files.

---
 rtl/fp_wb_scheduler.sv | 146 ++++++++++++++
 tb/tb_fp_wb_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_wb_scheduler.sv
// Shared FP writeback port arbiter: one buffered result per producer (LOAD, MOV, CVT),
// one registered grant per cycle. Optional macro FP_WB_X0_FILTER_EN suppresses INT x0 writes.
module fp_wb_scheduler #(
  parameter int DATA_W    = 32,
  parameter int RD_W      = 5,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic              mov_valid,
  input  logic              cvt_valid,
  output logic              ld_ready,
  output logic              mov_ready,
  output logic              cvt_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0] mov_data,
  input  logic [DATA_W-1:0] cvt_data,
  input  logic [RD_W-1:0]   ld_rd,
  input  logic [RD_W-1:0]   mov_rd,
  input  logic [RD_W-1:0]   cvt_rd,
  input  logic              ld_int,
  input  logic              mov_int,
  input  logic              cvt_int,
  input  logic              wb_hold,
  output logic [1:0]        wb_sel,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_fp_en,
  output logic              wb_int_en
);

  localparam int N = 3;

  logic [N-1:0]      in_valid, in_int, ready, accept, grant;
  logic [DATA_W-1:0] in_data [N];
  logic [RD_W-1:0]   in_rd [N];

  logic [N-1:0]      buf_v_reg, buf_int_reg;
  logic [DATA_W-1:0] buf_data_reg [N];
  logic [RD_W-1:0]   buf_rd_reg [N];
  logic [1:0]        last_reg;
  logic              ready_en_reg;

  logic [1:0]        start, cand, win;
  logic              any_grant, x0_drop;

  logic [1:0]        wb_sel_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic [RD_W-1:0]   wb_rd_reg;
  logic              wb_fp_en_reg, wb_int_en_reg;

  assign in_valid   = {cvt_valid, mov_valid, ld_valid};
  assign in_int     = {cvt_int, mov_int, ld_int};
  assign in_data[0] = ld_data;
  assign in_data[1] = mov_data;
  assign in_data[2] = cvt_data;
  assign in_rd[0]   = ld_rd;
  assign in_rd[1]   = mov_rd;
  assign in_rd[2]   = cvt_rd;
  assign {cvt_ready, mov_ready, ld_ready} = ready;

  function automatic logic [1:0] wrap3(input logic [2:0] s);
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Walk the search order backwards so the first occupied slot in order wins.
  always_comb begin
    start = (PRIO_MODE == 1) ? 2'd0 : wrap3({1'b0, last_reg} + 3'd1);
    win   = start;
    cand  = 2'd0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = wrap3({1'b0, start} + 3'(k));
      if (buf_v_reg[cand]) win = cand;
    end
    any_grant = (|buf_v_reg) & ~wb_hold;
    grant     = '0;
    if (any_grant) grant[win] = 1'b1;
  end

  // ready_en_reg keeps readys low until the first edge after reset release.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_port
      assign ready[gi]  = ready_en_reg & (~buf_v_reg[gi] | grant[gi]);
      assign accept[gi] = in_valid[gi] & ready[gi];
    end
  endgenerate

`ifdef FP_WB_X0_FILTER_EN
  assign x0_drop = (buf_rd_reg[win] == '0);
`else
  assign x0_drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_reg <= 1'b0;
      buf_v_reg    <= '0;
      buf_int_reg  <= '0;
      last_reg     <= 2'd2;
      for (int i = 0; i < N; i++) begin
        buf_data_reg[i] <= '0;
        buf_rd_reg[i]   <= '0;
      end
    end else begin
      ready_en_reg <= 1'b1;
      if (any_grant) last_reg <= win;
      for (int i = 0; i < N; i++) begin
        if (accept[i]) begin
          buf_v_reg[i]    <= 1'b1;
          buf_data_reg[i] <= in_data[i];
          buf_rd_reg[i]   <= in_rd[i];
          buf_int_reg[i]  <= in_int[i];
        end else if (grant[i]) begin
          buf_v_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_sel_reg    <= 2'b00;
      wb_data_reg   <= '0;
      wb_rd_reg     <= '0;
      wb_fp_en_reg  <= 1'b0;
      wb_int_en_reg <= 1'b0;
    end else begin
      wb_fp_en_reg  <= any_grant & ~buf_int_reg[win];
      wb_int_en_reg <= any_grant & buf_int_reg[win] & ~x0_drop;
      if (any_grant) begin
        wb_sel_reg  <= win;
        wb_data_reg <= buf_data_reg[win];
        wb_rd_reg   <= buf_rd_reg[win];
      end
    end
  end

  assign wb_sel    = wb_sel_reg;
  assign wb_data   = wb_data_reg;
  assign wb_rd     = wb_rd_reg;
  assign wb_fp_en  = wb_fp_en_reg;
  assign wb_int_en = wb_int_en_reg;

endmodule

// File: tb/tb_fp_wb_scheduler.sv
// Bench for fp_wb_scheduler: a round-robin and a fixed-priority instance, each checked
// every cycle against a queue-based reference model, plus directed scenario checks.
module tb_fp_wb_scheduler;

`ifdef FP_WB_X0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  v [2];
  logic [31:0] d [2][3];
  logic [4:0]  r [2][3];
  logic [2:0]  it [2];
  logic        hold [2];
  logic [2:0]  rdy [2];
  logic [1:0]  sel [2];
  logic [31:0] wd [2];
  logic [4:0]  wr [2];
  logic        fe [2];
  logic        ie [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      fp_wb_scheduler #(.DATA_W(32), .RD_W(5), .PRIO_MODE(gi)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(v[gi][0]), .mov_valid(v[gi][1]), .cvt_valid(v[gi][2]),
        .ld_ready(rdy[gi][0]), .mov_ready(rdy[gi][1]), .cvt_ready(rdy[gi][2]),
        .ld_data(d[gi][0]), .mov_data(d[gi][1]), .cvt_data(d[gi][2]),
        .ld_rd(r[gi][0]), .mov_rd(r[gi][1]), .cvt_rd(r[gi][2]),
        .ld_int(it[gi][0]), .mov_int(it[gi][1]), .cvt_int(it[gi][2]),
        .wb_hold(hold[gi]), .wb_sel(sel[gi]), .wb_data(wd[gi]), .wb_rd(wr[gi]),
        .wb_fp_en(fe[gi]), .wb_int_en(ie[gi])
      );
    end
  endgenerate

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  r;
    logic        i;
  } item_t;

  // Reference: pending results per (instance, producer) as queues.
  item_t       pend [6][$];
  int          last_m [2];
  bit          ren_m [2];
  int          win_m [2];
  logic [2:0]  acc_m [2];
  logic [1:0]  e_sel [2];
  logic [31:0] e_data [2];
  logic [4:0]  e_rd [2];
  logic        e_fe [2];
  logic        e_ie [2];

  int tests = 0;
  int fails = 0;
  int mode  = 0;  // 0: no new offers, 1: always offer, 2: random offers and hold
  int cnt [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) pend[i].delete();
    for (int m = 0; m < 2; m++) begin
      last_m[m] = 2;
      ren_m[m]  = 1'b0;
      e_sel[m]  = 2'b00;
      e_data[m] = 32'h0;
      e_rd[m]   = 5'h0;
      e_fe[m]   = 1'b0;
      e_ie[m]   = 1'b0;
    end
  endtask

  function automatic int pick(input int m);
    int start;
    int res;
    res = -1;
    if (!hold[m]) begin
      start = (m == 1) ? 0 : (last_m[m] + 1) % 3;
      for (int k = 0; k < 3; k++)
        if (res < 0 && pend[m*3 + (start + k) % 3].size() != 0) res = (start + k) % 3;
    end
    return res;
  endfunction

  task automatic offer(input int m, input int p, input logic [31:0] dd,
                       input logic [4:0] rr, input logic ii);
    v[m][p]  = 1'b1;
    d[m][p]  = dd;
    r[m][p]  = rr;
    it[m][p] = ii;
  endtask

  task automatic offer_rand(input int m, input int p);
    offer(m, p, $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)));
  endtask

  // One clock: check at the falling edge, then advance the model past the rising edge.
  task automatic step();
    logic [2:0] er;
    item_t x;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      win_m[m] = pick(m);
      for (int p = 0; p < 3; p++)
        er[p] = ren_m[m] && (pend[m*3+p].size() == 0 || win_m[m] == p);
      chk($sformatf("dut%0d ready", m), 32'(rdy[m]), 32'(er));
      chk($sformatf("dut%0d wb_sel", m), 32'(sel[m]), 32'(e_sel[m]));
      chk($sformatf("dut%0d wb_data", m), wd[m], e_data[m]);
      chk($sformatf("dut%0d wb_rd", m), 32'(wr[m]), 32'(e_rd[m]));
      chk($sformatf("dut%0d wb_fp_en", m), 32'(fe[m]), 32'(e_fe[m]));
      chk($sformatf("dut%0d wb_int_en", m), 32'(ie[m]), 32'(e_ie[m]));
      acc_m[m] = v[m] & er;
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      if (rst_n) begin
        if (win_m[m] >= 0) begin
          x = pend[m*3 + win_m[m]].pop_front();
          e_sel[m]  = 2'(win_m[m]);
          e_data[m] = x.d;
          e_rd[m]   = x.r;
          e_fe[m]   = !x.i;
          e_ie[m]   = x.i && !(FILT && x.r == 5'd0);
          last_m[m] = win_m[m];
        end else begin
          e_fe[m] = 1'b0;
          e_ie[m] = 1'b0;
        end
        for (int p = 0; p < 3; p++)
          if (acc_m[m][p]) pend[m*3+p].push_back(item_t'{d[m][p], r[m][p], it[m][p]});
        ren_m[m] = 1'b1;
      end
      for (int p = 0; p < 3; p++) begin
        if (acc_m[m][p]) v[m][p] = 1'b0;
        if (!v[m][p] && (mode == 1 || (mode == 2 && $urandom_range(1) == 1))) offer_rand(m, p);
      end
      if (mode == 2) hold[m] = ($urandom_range(3) == 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      hold[m] = 1'b0;
      for (int p = 0; p < 3; p++) offer_rand(m, p);
    end
    repeat (3) step();
    rst_n = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) chk("ready right after release", 32'(rdy[m]), 32'h0);
    mode = 1;
    step();
    for (int m = 0; m < 2; m++) chk("ready cycle after release", 32'(rdy[m]), 32'h7);
    repeat (8) step();
    mode = 0;
    repeat (8) step();

    // Single uncontended LOAD
    for (int m = 0; m < 2; m++) offer(m, 0, 32'h3F800000, 5'd5, 1'b0);
    step();
    step();
    for (int m = 0; m < 2; m++) begin
      chk("single load fp_en", 32'(fe[m]), 32'h1);
      chk("single load sel", 32'(sel[m]), 32'h0);
      chk("single load data", wd[m], 32'h3F800000);
      chk("single load rd", 32'(wr[m]), 32'h5);
    end
    step();
    for (int m = 0; m < 2; m++) chk("single load one cycle", 32'(fe[m]), 32'h0);

    // All buffers full under wb_hold, then release
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < 3; p++) offer_rand(m, p);
    step();
    for (int m = 0; m < 2; m++) hold[m] = 1'b1;
    repeat (4) begin
      step();
      for (int m = 0; m < 2; m++) begin
        chk("hold readys", 32'(rdy[m]), 32'h0);
        chk("hold enables", 32'(fe[m] | ie[m]), 32'h0);
      end
    end
    for (int m = 0; m < 2; m++) begin
      hold[m] = 1'b0;
      cnt[m]  = 0;
    end
    repeat (4) begin
      step();
      for (int m = 0; m < 2; m++) cnt[m] += int'(fe[m] | ie[m]);
    end
    for (int m = 0; m < 2; m++) chk("grants after release", 32'(cnt[m]), 32'h3);

    // MOV write to INT x0
    for (int m = 0; m < 2; m++) offer(m, 1, 32'h12345678, 5'd0, 1'b1);
    step();
    step();
    for (int m = 0; m < 2; m++) begin
      chk("x0 int_en", 32'(ie[m]), FILT ? 32'h0 : 32'h1);
      chk("x0 fp_en", 32'(fe[m]), 32'h0);
      chk("x0 data", wd[m], 32'h12345678);
      chk("x0 buffer freed", 32'(rdy[m][1]), 32'h1);
    end

    // Random traffic with a reset in the middle
    mode = 2;
    repeat (60) step();
    rst_n = 1'b0;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (400) step();
    mode = 0;
    for (int m = 0; m < 2; m++) hold[m] = 1'b0;
    repeat (10) step();
    for (int m = 0; m < 2; m++) chk("drained readys", 32'(rdy[m]), 32'h7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
